// File: rtl/vita_tx_control.sv
// vita_tx_control: plays timed sample-FIFO packets to the DSP on strobe, with late/underrun error handling
module vita_tx_control #(
  parameter int BASE = 0,
  parameter int MAXCHAN = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      set_stb,
  input  logic [7:0]                set_addr,
  input  logic [31:0]               set_data,
  input  logic [63:0]               vita_time,
  input  logic [68+32*MAXCHAN-1:0]  sample_fifo_i,
  input  logic                      sample_fifo_src_rdy_i,
  output logic                      sample_fifo_dst_rdy_o,
  input  logic                      strobe,
  output logic [32*MAXCHAN-1:0]     sample,
  output logic                      run,
  output logic                      error,
  output logic [1:0]                error_code
);
  localparam int SW = 32*MAXCHAN;
  typedef enum logic [1:0] {IDLE, WAIT_TIME, RUN, ERROR} state_t;
  state_t state, state_n;
  logic [1:0] code_n;
  logic dst_rdy, enter_err, start, code_clr;
  logic send_at, eob, eof;
  logic [63:0] send_time;
  logic [SW-1:0] samples;
  logic unused_bits;
  assign samples = sample_fifo_i[68+SW-1:68];
  assign send_at = sample_fifo_i[67];
  assign eob = sample_fifo_i[65];
  assign eof = sample_fifo_i[64];
  assign send_time = sample_fifo_i[63:0];
  assign unused_bits = ^{set_data, sample_fifo_i[66]};
  always_comb begin
    state_n = state;
    code_n = 2'd0;
    dst_rdy = 1'b0;
    case (state)
      IDLE:
        if (sample_fifo_src_rdy_i) begin
          if (!send_at) state_n = RUN;
          else if (send_time < vita_time) begin
            state_n = ERROR;
            code_n = 2'd2;
          end else state_n = WAIT_TIME;
        end
      WAIT_TIME:
        if (vita_time == send_time) state_n = RUN;
        else if (vita_time > send_time) begin
          state_n = ERROR;
          code_n = 2'd2;
        end
      RUN: begin
        dst_rdy = strobe & sample_fifo_src_rdy_i;
        if (strobe && !sample_fifo_src_rdy_i) begin
          state_n = ERROR;
          code_n = 2'd1;
        end else if (dst_rdy && eob) state_n = IDLE;
      end
      default: begin
        dst_rdy = 1'b1;
        if (sample_fifo_src_rdy_i && (eob || eof)) state_n = IDLE;
      end
    endcase
    if (clear) begin
      state_n = IDLE;
      dst_rdy = 1'b0;
    end
  end
  assign sample_fifo_dst_rdy_o = dst_rdy;
  assign run = state == RUN;
  assign enter_err = state_n == ERROR && state != ERROR;
  assign start = state == IDLE && (state_n == RUN || state_n == WAIT_TIME);
  assign code_clr = start || (set_stb && set_addr == 8'(BASE));
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sample <= '0;
      error <= 1'b0;
      error_code <= 2'd0;
    end else begin
      state <= state_n;
      error <= enter_err;
      error_code <= clear ? 2'd0 : enter_err ? code_n : code_clr ? 2'd0 : error_code;
      // Sample holds between strobes; any non-RUN state or an underrun strobe zeroes it
      sample <= (clear || state != RUN) ? '0 :
                (strobe && sample_fifo_src_rdy_i) ? samples :
                strobe ? '0 : sample;
    end
  end
endmodule

// File: tb/tb_vita_tx_control.sv
// tb_vita_tx_control: randomized packet-level checks of vita_tx_control against a queue-based reference
module tb_vita_tx_control;
  localparam int BASE = 8'h20;
  localparam int M = 2;
  localparam int SW = 32*M;
  localparam int EW = 68+SW;
  logic clk = 0, reset = 0, clear = 0, set_stb = 0, strobe = 0;
  logic [7:0] set_addr = 0;
  logic [31:0] set_data = 0;
  logic [63:0] vita_time;
  logic [EW-1:0] sample_fifo_i = '0;
  logic sample_fifo_src_rdy_i = 0;
  logic sample_fifo_dst_rdy_o, run, error;
  logic [SW-1:0] sample;
  logic [1:0] error_code;
  logic [EW-1:0] q[$];
  logic src_en = 1;
  int checks = 0, failures = 0;

  vita_tx_control #(.BASE(BASE), .MAXCHAN(M)) dut (
    .clk(clk), .reset(reset), .clear(clear), .set_stb(set_stb), .set_addr(set_addr),
    .set_data(set_data), .vita_time(vita_time), .sample_fifo_i(sample_fifo_i),
    .sample_fifo_src_rdy_i(sample_fifo_src_rdy_i), .sample_fifo_dst_rdy_o(sample_fifo_dst_rdy_o),
    .strobe(strobe), .sample(sample), .run(run), .error(error), .error_code(error_code)
  );

  always #5 clk = ~clk;

  function automatic logic [EW-1:0] mk(input logic sa, input logic eb, input logic [63:0] t, input logic [SW-1:0] d);
    return {d, sa, 1'b0, eb, 1'b0, t};
  endfunction

  function automatic logic [SW-1:0] rnd();
    return {$urandom, $urandom} | 64'd1;
  endfunction

  task automatic drive();
    sample_fifo_src_rdy_i = src_en && q.size() != 0;
    sample_fifo_i = q.size() != 0 ? q[0] : '0;
  endtask

  task automatic step();
    logic fired;
    @(negedge clk);
    fired = sample_fifo_dst_rdy_o && sample_fifo_src_rdy_i;
    @(posedge clk); #1;
    if (fired) void'(q.pop_front());
    vita_time = vita_time + 1;
    drive();
  endtask

  task automatic play(input int n, input int p, input string tag);
    logic [SW-1:0] d[$];
    for (int i = 0; i < n; i++) begin
      d.push_back(rnd());
      q.push_back(mk(1'b0, i == n-1, 64'd0, d[i]));
    end
    drive();
    repeat (2) step();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (run !== 1'b1) begin failures++; $display("FAIL %s_run_before_strobe%0d got=%b exp=1", tag, i, run); end
      strobe = 1;
      step();
      strobe = 0;
      checks++;
      if (sample !== d[i]) begin failures++; $display("FAIL %s_sample%0d got=%h exp=%h", tag, i, sample, d[i]); end
      checks++;
      if (run !== (i != n-1)) begin failures++; $display("FAIL %s_run_after_strobe%0d got=%b exp=%b", tag, i, run, i != n-1); end
      repeat (p-1) step();
    end
    checks++;
    if (q.size() != 0) begin failures++; $display("FAIL %s_drained got=%0d exp=0", tag, q.size()); end
    step();
    checks++;
    if (sample !== '0) begin failures++; $display("FAIL %s_sample_idle got=%h exp=0", tag, sample); end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({run, error, error_code, sample_fifo_dst_rdy_o} !== 5'b0 || sample !== '0) begin
      failures++; $display("FAIL reset_outputs got=%b/%h exp=0", {run, error, error_code, sample_fifo_dst_rdy_o}, sample);
    end
    @(posedge clk); #3 reset = 1;
    repeat (3) step();
    checks++;
    if ({run, error, error_code, sample_fifo_dst_rdy_o} !== 5'b0) begin
      failures++; $display("FAIL reset_idle got=%b exp=0", {run, error, error_code, sample_fifo_dst_rdy_o});
    end
  endtask

  task automatic test_random_bursts();
    for (int k = 0; k < 6; k++) play($urandom_range(6, 1), $urandom_range(5, 1), "rand");
  endtask

  task automatic test_timed();
    logic [63:0] t, v;
    logic [SW-1:0] d;
    bit seen = 0;
    t = vita_time + 100;
    d = rnd();
    q.push_back(mk(1'b1, 1'b1, t, d));
    drive();
    for (int i = 0; i < 200 && !seen; i++) begin
      v = vita_time;
      step();
      if (v < t && (run !== 1'b0 || q.size() != 1)) begin
        checks++; failures++; $display("FAIL timed_early got=run%b/q%0d exp=run0/q1 at t-%0d", run, q.size(), t - v);
      end
      if (v == t) begin
        seen = 1;
        checks++;
        if (run !== 1'b1) begin failures++; $display("FAIL timed_start got=%b exp=1", run); end
      end
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL timed_timeout got=0 exp=1"); end
    checks++;
    if (q.size() != 1) begin failures++; $display("FAIL timed_not_consumed got=%0d exp=1", q.size()); end
    strobe = 1;
    step();
    strobe = 0;
    checks++;
    if (sample !== d || run !== 1'b0) begin failures++; $display("FAIL timed_play got=%h/%b exp=%h/0", sample, run, d); end
  endtask

  task automatic test_late();
    int pulses = 0;
    q.push_back(mk(1'b1, 1'b0, vita_time - 1, rnd()));
    q.push_back(mk(1'b0, 1'b0, 64'd0, rnd()));
    q.push_back(mk(1'b0, 1'b1, 64'd0, rnd()));
    drive();
    strobe = 1;
    repeat (10) begin
      step();
      if (error) pulses++;
    end
    strobe = 0;
    checks++;
    if (pulses != 1) begin failures++; $display("FAIL late_pulses got=%0d exp=1", pulses); end
    checks++;
    if (error_code !== 2'd2) begin failures++; $display("FAIL late_code got=%0d exp=2", error_code); end
    checks++;
    if (q.size() != 0 || run !== 1'b0 || sample !== '0) begin
      failures++; $display("FAIL late_drain got=q%0d/run%b/%h exp=q0/run0/0", q.size(), run, sample);
    end
    set_stb = 1; set_addr = BASE; set_data = $urandom;
    step();
    set_stb = 0;
    checks++;
    if (error_code !== 2'd0) begin failures++; $display("FAIL late_code_clear got=%0d exp=0", error_code); end
  endtask

  task automatic test_underrun();
    logic [SW-1:0] d0;
    d0 = rnd();
    q.push_back(mk(1'b0, 1'b0, 64'd0, d0));
    q.push_back(mk(1'b0, 1'b0, 64'd0, rnd()));
    q.push_back(mk(1'b0, 1'b1, 64'd0, rnd()));
    drive();
    repeat (2) step();
    strobe = 1;
    step();
    checks++;
    if (sample !== d0) begin failures++; $display("FAIL underrun_first got=%h exp=%h", sample, d0); end
    src_en = 0;
    drive();
    step();
    strobe = 0;
    checks++;
    if (error_code !== 2'd1 || sample !== '0 || run !== 1'b0 || error !== 1'b1) begin
      failures++; $display("FAIL underrun_state got=code%0d/%h/run%b/err%b exp=code1/0/run0/err1", error_code, sample, run, error);
    end
    src_en = 1;
    drive();
    repeat (4) step();
    checks++;
    if (q.size() != 0 || error !== 1'b0 || error_code !== 2'd1) begin
      failures++; $display("FAIL underrun_drain got=q%0d/err%b/code%0d exp=q0/err0/code1", q.size(), error, error_code);
    end
    set_stb = 1; set_addr = BASE + 1;
    step();
    checks++;
    if (error_code !== 2'd1) begin failures++; $display("FAIL underrun_wrong_addr got=%0d exp=1", error_code); end
    set_addr = BASE;
    step();
    set_stb = 0;
    checks++;
    if (error_code !== 2'd0) begin failures++; $display("FAIL underrun_code_clear got=%0d exp=0", error_code); end
  endtask

  task automatic test_clear();
    logic [SW-1:0] d0;
    q.push_back(mk(1'b1, 1'b1, vita_time + 1000, rnd()));
    drive();
    repeat (5) step();
    clear = 1;
    step();
    clear = 0;
    checks++;
    if (q.size() != 1 || run !== 1'b0 || error_code !== 2'd0) begin
      failures++; $display("FAIL clear_wait got=q%0d/run%b exp=q1/run0", q.size(), run);
    end
    q.delete();
    drive();
    clear = 1; step(); clear = 0;
    d0 = rnd();
    q.push_back(mk(1'b0, 1'b0, 64'd0, d0));
    q.push_back(mk(1'b0, 1'b1, 64'd0, rnd()));
    drive();
    repeat (2) step();
    strobe = 1;
    step();
    checks++;
    if (sample !== d0 || run !== 1'b1) begin failures++; $display("FAIL clear_run_setup got=%h/%b exp=%h/1", sample, run, d0); end
    clear = 1;
    step();
    strobe = 0;
    clear = 0;
    checks++;
    if (q.size() != 1 || run !== 1'b0 || sample !== '0 || error !== 1'b0) begin
      failures++; $display("FAIL clear_run got=q%0d/run%b/%h exp=q1/run0/0", q.size(), run, sample);
    end
    q.delete();
    drive();
    clear = 1; step(); clear = 0;
  endtask

  task automatic test_reset_mid_run();
    logic [SW-1:0] d0;
    d0 = rnd();
    q.push_back(mk(1'b0, 1'b0, 64'd0, d0));
    q.push_back(mk(1'b0, 1'b1, 64'd0, rnd()));
    drive();
    repeat (2) step();
    strobe = 1;
    step();
    strobe = 0;
    checks++;
    if (sample !== d0 || run !== 1'b1) begin failures++; $display("FAIL rstmid_setup got=%h/%b exp=%h/1", sample, run, d0); end
    strobe = 1;
    #2 reset = 0;
    #1;
    checks++;
    if ({run, error, error_code, sample_fifo_dst_rdy_o} !== 5'b0 || sample !== '0) begin
      failures++; $display("FAIL rstmid_async got=%b/%h exp=0", {run, error, error_code, sample_fifo_dst_rdy_o}, sample);
    end
    strobe = 0;
    q.delete();
    drive();
    repeat (2) @(posedge clk);
    #3 reset = 1;
    play(3, 3, "post_reset");
  endtask

  initial begin
    vita_time = {1'b0, 31'($urandom), $urandom};
    test_reset();
    play(3, 4, "burst");
    test_random_bursts();
    test_timed();
    test_late();
    test_underrun();
    test_clear();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
